// File: rtl/gobou_ctrl_delay_if.sv
// ctrl_bus: start/valid/stop control triple shared by gobou pipeline stages.
interface ctrl_bus;
    logic start;
    logic valid;
    logic stop;

    modport master (output start, output valid, output stop);
    modport slave  (input  start, input  valid, input  stop);
endinterface

// File: rtl/gobou_ctrl_delay.sv
// gobou_ctrl_delay: stallable control-bus delay line with a per-frame latched
// latency, early output-enable strobes and frame-occupancy tracking.
// Optional protocol checker enabled by defining GOBOU_CTRL_DELAY_ERR_EN;
// without it err is tied low and err_clr is ignored.
module gobou_ctrl_delay #(
    parameter int unsigned D_MAX = 8,
    parameter int unsigned N_OE  = 2,
    parameter int unsigned DW    = $clog2(D_MAX + 1)
) (
    input  logic            clk,
    input  logic            xrst,
    ctrl_bus.slave          in_ctrl,
    ctrl_bus.master         out_ctrl,
    input  logic [DW-1:0]   delay,
    input  logic            stall,
    output logic [N_OE-1:0] oe,
    output logic            busy,
    output logic            err,
    input  logic            err_clr
);

    // stage bit layout: [2]=start, [1]=valid, [0]=stop
    logic [2:0]    sr_q [D_MAX];
    logic [2:0]    sr_d [D_MAX];
    logic [DW-1:0] lat_q, lat_d;
    logic          busy_q, busy_d;
    logic [DW-1:0] leff;
    logic [DW-1:0] lat_sel;
    int unsigned   lat_n;
    logic [2:0]    in_v;
    logic [2:0]    out_v;
    logic          accept;

    assign in_v   = {in_ctrl.start, in_ctrl.valid, in_ctrl.stop};
    assign accept = in_ctrl.start & ~busy_q & ~stall;

    // clamp the requested latency to 1..D_MAX; the accepting cycle already uses it
    always_comb begin
        if (delay == '0) begin
            leff = DW'(1);
        end else if (delay > DW'(D_MAX)) begin
            leff = DW'(D_MAX);
        end else begin
            leff = delay;
        end
        lat_sel = accept ? leff : lat_q;
        lat_n   = 32'(lat_sel);
    end

    // tap selection, early strobes and next stage contents
    always_comb begin
        sr_d  = sr_q;
        out_v = '0;
        oe    = '0;
        for (int unsigned i = 0; i < D_MAX; i++) begin
            if (i + 1 == lat_n) begin
                out_v = sr_q[i];
            end
        end
        for (int unsigned k = 0; k < N_OE; k++) begin
            for (int unsigned j = 0; j < D_MAX; j++) begin
                if (j + 2 + k == lat_n) begin
                    oe[k] = sr_q[j][1];
                end
            end
            if (k + 1 == lat_n) begin
                oe[k] = in_ctrl.valid;
            end
        end
        if (stall) begin
            out_v = '0;
            oe    = '0;
        end else begin
            // stages past the active tap are flushed so that a later, longer
            // latency cannot re-present pulses that were already output
            sr_d[0] = in_v;
            for (int unsigned i = 1; i < D_MAX; i++) begin
                sr_d[i] = (i < lat_n) ? sr_q[i-1] : '0;
            end
        end
    end

    // frame occupancy and latency latch; an accepted start outranks an output stop
    always_comb begin
        lat_d  = accept ? leff : lat_q;
        busy_d = busy_q;
        if (accept) begin
            busy_d = 1'b1;
        end else if (out_v[0]) begin
            busy_d = 1'b0;
        end
    end

    // state registers
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            sr_q   <= '{default: '0};
            lat_q  <= DW'(D_MAX);
            busy_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            lat_q  <= lat_d;
            busy_q <= busy_d;
        end
    end

    assign out_ctrl.start = out_v[2];
    assign out_ctrl.valid = out_v[1];
    assign out_ctrl.stop  = out_v[0];
    assign busy           = busy_q;

`ifdef GOBOU_CTRL_DELAY_ERR_EN
    logic err_q, err_d, err_set;

    // detect protocol violations; a new violation outranks a clear
    always_comb begin
        if (stall) begin
            err_set = |in_v;
        end else begin
            err_set = (in_ctrl.start & busy_q)
                    | ((in_ctrl.valid | in_ctrl.stop) & ~busy_q & ~in_ctrl.start);
        end
        err_d = err_q;
        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    // sticky error register
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err            = 1'b0;
`endif

endmodule
